// File: rtl/mem_bus_unit_pkg.sv
// Shared definitions for the memory bus unit.
//   SIZE_W / SIZE_*  : access-size codes carried on SIZE and in the write buffer
//   dstate_t         : data-side bus sequencer states
package mem_bus_unit_pkg;

    localparam int SIZE_W = 2;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        D_IDLE  = 2'b00,
        D_WRITE = 2'b01,
        D_READ  = 2'b10
    } dstate_t;

endpackage

// File: rtl/mem_bus_unit_wbuf_fifo.sv
// Write buffer: DEPTH x {addr, size, data} synchronous FIFO.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   push, pop                       enqueue tail / dequeue head (same edge allowed)
//   in_addr, in_size, in_data       entry written on push
//   head_addr, head_size, head_data oldest entry (valid while !empty)
//   full, empty, count              occupancy status
module wbuf_fifo
    import mem_bus_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [XLEN-1:0]         in_addr,
    input  logic [SIZE_W-1:0]       in_size,
    input  logic [XLEN-1:0]         in_data,
    output logic [XLEN-1:0]         head_addr,
    output logic [SIZE_W-1:0]       head_size,
    output logic [XLEN-1:0]         head_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   addr_mem [DEPTH];
    logic [SIZE_W-1:0] size_mem [DEPTH];
    logic [XLEN-1:0]   data_mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_addr = addr_mem[rd_ptr];
    assign head_size = size_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage carries no reset; occupancy alone defines validity.
    // A push into a full buffer is only issued together with a pop, so the
    // slot at wr_ptr has already been consumed on this same edge.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= in_addr;
            size_mem[wr_ptr] <= in_size;
            data_mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: rtl/mem_bus_unit.sv
// Bus interface unit between the core and the IAD/IDT (fetch) and DAD/DDT
// (data) buses. Stores are posted into a write buffer and drained in order;
// loads wait for the buffer to empty, then run one read cycle and return
// registered data with a one-cycle o_rdValid pulse.
// Optional feature: define BUS_TIMEOUT_EN to enable a bus watchdog that
// aborts a data cycle after TIMEOUT unacknowledged cycles (o_busErr pulse).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_PC / IAD, IDT / o_inst       fetch address and instruction pass-through
//   ACKI_n / o_fetchStall          fetch wait state
//   i_memReq, i_memWrite,
//   i_memSize, i_addr, i_wdata     core data access request
//   o_rdata, o_rdValid             load result
//   o_dStall, o_busErr             core hold / watchdog abort pulse
//   DAD, MREQ, WRITE, SIZE         data bus control
//   o_ddtOut, o_ddtOe, i_ddtIn     DDT drive value, enable and sampled value
//   ACKD_n                         data ack, active-low
module mem_bus_unit
    import mem_bus_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int WB_DEPTH = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   i_PC,
    output logic [XLEN-1:0]   o_inst,
    output logic              o_fetchStall,
    input  logic              i_memReq,
    input  logic              i_memWrite,
    input  logic [SIZE_W-1:0] i_memSize,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_rdValid,
    output logic              o_dStall,
    output logic              o_busErr,
    output logic [XLEN-1:0]   IAD,
    input  logic [XLEN-1:0]   IDT,
    input  logic              ACKI_n,
    output logic [XLEN-1:0]   DAD,
    output logic              MREQ,
    output logic              WRITE,
    output logic [SIZE_W-1:0] SIZE,
    output logic [XLEN-1:0]   o_ddtOut,
    output logic              o_ddtOe,
    input  logic [XLEN-1:0]   i_ddtIn,
    input  logic              ACKD_n
);

    localparam int CW = $clog2(WB_DEPTH) + 1;

    dstate_t           state;
    dstate_t           state_nxt;
    logic [XLEN-1:0]   rd_addr;
    logic [SIZE_W-1:0] rd_size;
    logic              bus_active;
    logic              bus_ack;
    logic              timeout_hit;
    logic              done;
    logic              load_req;
    logic              store_req;
    logic              load_pending;
    logic              push;
    logic              pop;
    logic              wb_full;
    logic              wb_empty;
    logic [CW-1:0]     wb_count;
    logic [XLEN-1:0]   head_addr;
    logic [XLEN-1:0]   head_data;
    logic [SIZE_W-1:0] head_size;

    // Fetch side is a pure pass-through.
    assign IAD          = i_PC;
    assign o_inst       = IDT;
    assign o_fetchStall = ACKI_n;

    assign load_req  = i_memReq & ~i_memWrite;
    assign store_req = i_memReq &  i_memWrite;
    // While o_rdValid is high the held load is being retired, not reissued.
    assign load_pending = load_req & ~o_rdValid;

    assign bus_active = (state != D_IDLE);
    assign bus_ack    = bus_active & ~ACKD_n;
    assign done       = bus_ack | timeout_hit;

    assign pop  = (state == D_WRITE) & done;
    assign push = store_req & (~wb_full | pop);

    assign o_dStall = (store_req & wb_full & ~pop) | (load_req & ~o_rdValid);

    // Bus pins derive only from registered state and buffer contents.
    assign MREQ     = bus_active;
    assign WRITE    = (state == D_WRITE);
    assign o_ddtOe  = WRITE;
    assign DAD      = WRITE ? head_addr : rd_addr;
    assign SIZE     = WRITE ? head_size : rd_size;
    assign o_ddtOut = WRITE ? head_data : '0;

    wbuf_fifo #(
        .XLEN  (XLEN),
        .DEPTH (WB_DEPTH)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .in_addr   (i_addr),
        .in_size   (i_memSize),
        .in_data   (i_wdata),
        .head_addr (head_addr),
        .head_size (head_size),
        .head_data (head_data),
        .full      (wb_full),
        .empty     (wb_empty),
        .count     (wb_count)
    );

    // Draining has priority over loads so a load never passes an older store.
    always_comb begin
        state_nxt = state;
        case (state)
            D_IDLE: begin
                if (!wb_empty)         state_nxt = D_WRITE;
                else if (load_pending) state_nxt = D_READ;
            end
            D_WRITE: begin
                if (pop) begin
                    if ((wb_count > CW'(1)) || push) state_nxt = D_WRITE;
                    else if (load_pending)           state_nxt = D_READ;
                    else                             state_nxt = D_IDLE;
                end
            end
            D_READ: begin
                if (done) state_nxt = D_IDLE;
            end
            default: state_nxt = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= D_IDLE;
            rd_addr   <= '0;
            rd_size   <= '0;
            o_rdata   <= '0;
            o_rdValid <= 1'b0;
        end else begin
            state <= state_nxt;
            // The core holds i_addr/i_memSize while stalled, so capturing on
            // every read-bound cycle keeps DAD/SIZE stable across wait states.
            if (state_nxt == D_READ) begin
                rd_addr <= i_addr;
                rd_size <= i_memSize;
            end
            o_rdValid <= (state == D_READ) & done;
            if ((state == D_READ) && bus_ack)
                o_rdata <= i_ddtIn;
            else if ((state == D_READ) && timeout_hit)
                o_rdata <= '0;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;

    // Counts unacknowledged cycles of the current bus cycle; restarts at
    // every completion so back-to-back writes each get a full budget.
    assign timeout_hit = bus_active & ACKD_n & (wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || !bus_active || done)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) o_busErr <= 1'b0;
        else     o_busErr <= timeout_hit;
    end
`else
    assign timeout_hit = 1'b0;
    assign o_busErr    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_unit.sv
// Testbench for mem_bus_unit: directed vectors with literal expectations plus
// a transaction-level model (write-buffer queue, pending read result) checked
// against the DUT on every non-reset cycle.
`timescale 1ns/1ps
module tb_mem_bus_unit;
    import mem_bus_unit_pkg::*;

    localparam int DEPTH = 2;
`ifdef BUS_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, idt, addr, wdata, ddt_in;
    logic        acki_n, ackd_n, memReq, memWrite;
    logic [1:0]  memSize;
    logic [31:0] o_inst, o_rdata, IAD, DAD, o_ddtOut;
    logic        o_fetchStall, o_rdValid, o_dStall, o_busErr, MREQ, WRITE, o_ddtOe;
    logic [1:0]  SIZE;

    always #5 clk = ~clk;

    mem_bus_unit #(.XLEN(32), .WB_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .i_PC(pc), .o_inst(o_inst), .o_fetchStall(o_fetchStall),
        .i_memReq(memReq), .i_memWrite(memWrite), .i_memSize(memSize), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(o_rdata), .o_rdValid(o_rdValid), .o_dStall(o_dStall),
        .o_busErr(o_busErr), .IAD(IAD), .IDT(idt), .ACKI_n(acki_n), .DAD(DAD), .MREQ(MREQ),
        .WRITE(WRITE), .SIZE(SIZE), .o_ddtOut(o_ddtOut), .o_ddtOe(o_ddtOe),
        .i_ddtIn(ddt_in), .ACKD_n(ackd_n)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  s;
        logic [31:0] d;
    } ent_t;

    ent_t        wq[$];
    logic        exp_rv = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rdata = '0;
    int          wc = 0;
    logic        s_mreq = 1'b0;
    logic        s_write = 1'b0;

    always @(negedge clk) begin
        logic abort_now, pop_now, st, ld, full;
        if (!rst) begin
            chk("iad", IAD, pc);
            chk("inst", o_inst, idt);
            chk("fetch_stall", o_fetchStall, acki_n);
            chk("ddt_oe", o_ddtOe, WRITE);
            chk("rd_valid", o_rdValid, exp_rv);
            if (exp_rv) chk("rdata", o_rdata, exp_rdata);
            chk("bus_err", o_busErr, exp_err);
            abort_now = TO_EN && MREQ && ackd_n && (wc + 1 == TO);
            pop_now   = MREQ && WRITE && (!ackd_n || abort_now);
            st   = memReq && memWrite;
            ld   = memReq && !memWrite;
            full = (wq.size() == DEPTH);
            chk("dstall", o_dStall, (st && full && !pop_now) || (ld && !exp_rv));
            if (MREQ && WRITE) begin
                if (wq.size() == 0) chk("write_with_empty_buffer", WRITE, 0);
                else begin
                    chk("wr_dad", DAD, wq[0].a);
                    chk("wr_size", SIZE, wq[0].s);
                    chk("wr_data", o_ddtOut, wq[0].d);
                end
            end else if (MREQ) begin
                if (wq.size() != 0) chk("read_while_buffer_busy", MREQ, 0);
                else if (!ld)       chk("read_without_load", MREQ, 0);
                else begin
                    chk("rd_dad", DAD, addr);
                    chk("rd_size", SIZE, memSize);
                end
            end else begin
                chk("write_without_mreq", WRITE, 0);
            end
        end
        s_mreq  = MREQ;
        s_write = WRITE;
    end

    always @(posedge clk) begin
        logic ab, rd_m, pop_m, full_b;
        ent_t e;
        if (rst) begin
            wq.delete();
            exp_rv  = 1'b0;
            exp_err = 1'b0;
            wc      = 0;
        end else begin
            ab = 1'b0;
            if (s_mreq && ackd_n) begin
                if (TO_EN && (wc + 1 == TO)) begin ab = 1'b1; wc = 0; end
                else wc++;
            end else wc = 0;
            rd_m  = s_mreq && !s_write && (!ackd_n || ab);
            pop_m = s_mreq &&  s_write && (!ackd_n || ab);
            exp_rv  = rd_m;
            exp_err = ab;
            if (rd_m) exp_rdata = ab ? 32'h0 : ddt_in;
            full_b = (wq.size() == DEPTH);
            if (pop_m && wq.size() > 0) void'(wq.pop_front());
            if (memReq && memWrite && (!full_b || pop_m)) begin
                e.a = addr; e.s = memSize; e.d = wdata;
                wq.push_back(e);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nb();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; memReq = 1'b0; memWrite = 1'b0; memSize = SIZE_WORD;
        addr = '0; wdata = '0; ddt_in = '0; ackd_n = 1'b1; acki_n = 1'b1;
        pc = '0; idt = '0;
        repeat (2) step();
        nb();
        chk("rst_mreq", MREQ, 0);
        chk("rst_write", WRITE, 0);
        chk("rst_size", SIZE, 0);
        chk("rst_dad", DAD, 0);
        chk("rst_ddtoe", o_ddtOe, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_rdvalid", o_rdValid, 0);
        chk("rst_buserr", o_busErr, 0);
        step(); rst = 1'b0;

        // fetch pass-through
        pc = 32'h0000_1234; idt = 32'hCAFE_F00D; acki_n = 1'b1;
        nb();
        chk("f_iad", IAD, 32'h0000_1234);
        chk("f_inst", o_inst, 32'hCAFE_F00D);
        chk("f_stall_1", o_fetchStall, 1);
        step(); acki_n = 1'b0;
        nb();
        chk("f_stall_0", o_fetchStall, 0);

        // load with immediate ack
        step(); memReq = 1; memWrite = 0; memSize = SIZE_WORD; addr = 32'h40;
        ackd_n = 0; ddt_in = 32'hDEAD_BEEF;
        nb(); chk("ld0_mreq_n", MREQ, 0); chk("ld0_stall_n", o_dStall, 1);
        step(); nb();
        chk("ld0_mreq_n1", MREQ, 1); chk("ld0_dad", DAD, 32'h40); chk("ld0_rv_n1", o_rdValid, 0);
        step(); nb();
        chk("ld0_mreq_n2", MREQ, 0); chk("ld0_rv_n2", o_rdValid, 1);
        chk("ld0_rdata", o_rdata, 32'hDEAD_BEEF); chk("ld0_stall_n2", o_dStall, 0);
        step(); memReq = 0; ackd_n = 1; nb();
        chk("ld0_rv_n3", o_rdValid, 0);

        // load with three wait states
        step(); memReq = 1; memWrite = 0; memSize = SIZE_HALF; addr = 32'h80;
        ackd_n = 1; ddt_in = 32'h1234_5678;
        nb(); chk("ld3_stall_n", o_dStall, 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 4) ackd_n = 0;
            nb();
            chk("ld3_mreq", MREQ, 1); chk("ld3_dad", DAD, 32'h80);
            chk("ld3_size", SIZE, SIZE_HALF); chk("ld3_stall", o_dStall, 1);
        end
        step(); nb();
        chk("ld3_mreq_end", MREQ, 0); chk("ld3_rv", o_rdValid, 1);
        chk("ld3_rdata", o_rdata, 32'h1234_5678); chk("ld3_stall_end", o_dStall, 0);
        step(); memReq = 0; ackd_n = 1;

        // three back-to-back stores into a two-entry buffer
        step(); memReq = 1; memWrite = 1; memSize = SIZE_WORD; addr = 32'h200; wdata = 32'h1111_1111;
        nb(); chk("st_s0_stall", o_dStall, 0);
        step(); addr = 32'h204; wdata = 32'h2222_2222;
        nb(); chk("st_s1_stall", o_dStall, 0); chk("st_s1_mreq", MREQ, 0);
        step(); addr = 32'h208; wdata = 32'h3333_3333;
        nb(); chk("st_s2_write", WRITE, 1); chk("st_s2_dad", DAD, 32'h200);
        chk("st_s2_data", o_ddtOut, 32'h1111_1111); chk("st_s2_oe", o_ddtOe, 1);
        chk("st_s2_stall", o_dStall, 1);
        step(); nb(); chk("st_s3_stall", o_dStall, 1); chk("st_s3_dad", DAD, 32'h200);
        step(); ackd_n = 0;
        nb(); chk("st_s4_stall", o_dStall, 0); chk("st_s4_dad", DAD, 32'h200);
        step(); memReq = 0;
        nb(); chk("st_s5_dad", DAD, 32'h204); chk("st_s5_data", o_ddtOut, 32'h2222_2222);
        step(); nb(); chk("st_s6_dad", DAD, 32'h208); chk("st_s6_data", o_ddtOut, 32'h3333_3333);
        step(); ackd_n = 1;
        nb(); chk("st_s7_mreq", MREQ, 0); chk("st_s7_oe", o_ddtOe, 0);

        // store then load to the same address: load waits for the write ack
        step(); memReq = 1; memWrite = 1; memSize = SIZE_WORD; addr = 32'h100; wdata = 32'hA5A5_A5A5;
        nb(); chk("sl_t0_stall", o_dStall, 0);
        step(); memWrite = 0; memSize = SIZE_BYTE; ddt_in = 32'h5A5A_0001;
        nb(); chk("sl_t1_stall", o_dStall, 1); chk("sl_t1_mreq", MREQ, 0);
        step(); nb(); chk("sl_t2_write", WRITE, 1); chk("sl_t2_dad", DAD, 32'h100);
        step(); ackd_n = 0;
        nb(); chk("sl_t3_write", WRITE, 1);
        step(); nb(); chk("sl_t4_mreq", MREQ, 1); chk("sl_t4_write", WRITE, 0);
        chk("sl_t4_size", SIZE, SIZE_BYTE); chk("sl_t4_stall", o_dStall, 1);
        step(); nb(); chk("sl_t5_rv", o_rdValid, 1); chk("sl_t5_rdata", o_rdata, 32'h5A5A_0001);
        chk("sl_t5_mreq", MREQ, 0);
        step(); memReq = 0; ackd_n = 1;

        // reset during a read cycle
        step(); memReq = 1; memWrite = 0; memSize = SIZE_WORD; addr = 32'h300; ddt_in = 32'hBAD0_BAD0;
        nb();
        step(); nb(); chk("rr_mreq_before", MREQ, 1);
        step(); rst = 1; ackd_n = 0;
        nb();
        step(); rst = 0; memReq = 0; ackd_n = 1;
        nb(); chk("rr_mreq_after", MREQ, 0); chk("rr_rv_after", o_rdValid, 0);
        chk("rr_rdata_after", o_rdata, 0);
        step(); nb(); chk("rr_rv_later", o_rdValid, 0);

        // reset discards buffered stores
        step(); memReq = 1; memWrite = 1; addr = 32'h500; wdata = 32'h1;
        nb();
        step(); addr = 32'h504; wdata = 32'h2;
        nb();
        step(); memReq = 0;
        nb(); chk("wr_rst_pre_mreq", MREQ, 1);
        step(); rst = 1;
        nb();
        step(); rst = 0;
        nb(); chk("wr_rst_mreq", MREQ, 0);
        for (int i = 0; i < 3; i++) begin
            step(); nb(); chk("wr_rst_flushed", MREQ, 0);
        end

`ifdef BUS_TIMEOUT_EN
        // watchdog abort of a load
        step(); memReq = 1; memWrite = 0; memSize = SIZE_WORD; addr = 32'h400;
        ackd_n = 1; ddt_in = 32'hFFFF_FFFF;
        nb();
        for (int i = 1; i <= 4; i++) begin
            step(); nb(); chk("to_mreq", MREQ, 1); chk("to_err_low", o_busErr, 0);
        end
        step(); nb();
        chk("to_mreq_drop", MREQ, 0); chk("to_err", o_busErr, 1);
        chk("to_rv", o_rdValid, 1); chk("to_rdata", o_rdata, 0); chk("to_stall", o_dStall, 0);
        step(); memReq = 0;
        nb(); chk("to_err_pulse", o_busErr, 0);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
